// File: rtl/adc_pkt_streamer.sv
// Multi-channel ADC packet streamer: latches sample sets and serialises
// enabled channels into headered, gap-separated packets on a divided read clock.
module adc_pkt_streamer #(
    parameter int DATA_W = 18,
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8,
    parameter int IDLE_W = 8,
    parameter int CNT_W  = 16,
    parameter logic [DATA_W-1:0] HDR_MARK = 18'h3A5A5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     capture_start,
    input  logic                     self_test_mode,
    input  logic [DIV_W-1:0]         clk_div,
    input  logic [IDLE_W-1:0]        idle_length,
    input  logic [CNT_W-1:0]         pkt_length,
    input  logic [CNT_W-1:0]         num_pkts,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH*DATA_W-1:0] adc_data,
    input  logic                     adc_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic                     out_sop,
    output logic                     out_clk_rd,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    logic [2:0]               state;
    logic [DIV_W-1:0]         d_l;
    logic [DIV_W-1:0]         d_in;
    logic [DIV_W-1:0]         div_cnt;
    logic [IDLE_W-1:0]        idle_l;
    logic [IDLE_W-1:0]        gap_cnt;
    logic [CNT_W-1:0]         plen_l;
    logic [CNT_W-1:0]         npk_l;
    logic [CNT_W-1:0]         set_cnt;
    logic [CNT_W-1:0]         pkt_cnt;
    logic [NUM_CH-1:0]        en_l;
    logic [NUM_CH-1:0]        pend;
    logic [NUM_CH-1:0]        low;
    logic [NUM_CH-1:0]        pend_nx;
    logic                     st_l;
    logic                     full;
    logic [DATA_W-1:0]        sample_idx;
    logic [DATA_W-1:0]        emit_word;
    logic [NUM_CH*DATA_W-1:0] shadow;
    logic [NUM_CH*DATA_W-1:0] st_pat;
    logic                     tick;
    logic                     in_data;
    logic                     emit;
    logic                     emptying;
    logic                     load_adc;
    logic                     load_st;
    logic                     ovf_ev;
    logic                     cfg_ok;
    logic                     start_ok;

    assign d_in       = (clk_div < DIV_W'(2)) ? DIV_W'(2) : clk_div;
    assign tick       = busy && (div_cnt == d_l - DIV_W'(1));
    assign out_clk_rd = busy && (div_cnt >= (d_l >> 1));
    assign in_data    = (state == S_DATA);
    assign cfg_ok     = (pkt_length != '0) && (num_pkts != '0) && (ch_en != '0);
    assign start_ok   = (state == S_IDLE) && capture_start && cfg_ok;

    // pend holds channels of the current set still to be sent; low is the next one
    assign low      = pend & (~pend + NUM_CH'(1));
    assign pend_nx  = pend & ~low;
    assign emit     = tick && in_data && full;
    assign emptying = emit && (pend_nx == '0);
    assign load_adc = !st_l && adc_valid && in_data && (!full || emptying);
    assign load_st  = st_l && in_data && !full;
    assign ovf_ev   = !st_l && adc_valid && in_data && full && !emptying;

    always_comb begin
        emit_word = '0;
        st_pat    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (low[k]) emit_word = shadow[k*DATA_W +: DATA_W];
            st_pat[k*DATA_W +: DATA_W] = sample_idx + DATA_W'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            d_l        <= '0;
            div_cnt    <= '0;
            idle_l     <= '0;
            gap_cnt    <= '0;
            plen_l     <= '0;
            npk_l      <= '0;
            set_cnt    <= '0;
            pkt_cnt    <= '0;
            en_l       <= '0;
            pend       <= '0;
            st_l       <= 1'b0;
            full       <= 1'b0;
            sample_idx <= '0;
            shadow     <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy) div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (ovf_ev) overflow <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (capture_start) begin
                        d_l    <= d_in;
                        idle_l <= idle_length;
                        plen_l <= pkt_length;
                        npk_l  <= num_pkts;
                        en_l   <= ch_en;
                        st_l   <= self_test_mode;
                        if (cfg_ok) begin
                            state    <= S_HDR;
                            busy     <= 1'b1;
                            div_cnt  <= '0;
                            overflow <= 1'b0;
                            set_cnt  <= '0;
                            pkt_cnt  <= '0;
                            gap_cnt  <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_HDR: begin
                    if (tick) begin
                        out_data   <= HDR_MARK;
                        out_valid  <= 1'b1;
                        out_sop    <= 1'b1;
                        sample_idx <= '0;
                        state      <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        out_sop   <= 1'b0;
                        out_valid <= full;
                        if (full) out_data <= emit_word;
                        if (emptying) begin
                            if (set_cnt == plen_l - CNT_W'(1)) begin
                                set_cnt <= '0;
                                if (pkt_cnt == npk_l - CNT_W'(1)) begin
                                    state <= S_FIN;
                                end else begin
                                    pkt_cnt <= pkt_cnt + CNT_W'(1);
                                    gap_cnt <= '0;
                                    state   <= (idle_l == '0) ? S_HDR : S_GAP;
                                end
                            end else begin
                                set_cnt <= set_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        out_valid <= 1'b0;
                        out_sop   <= 1'b0;
                        if (gap_cnt == idle_l - IDLE_W'(1)) begin
                            gap_cnt <= '0;
                            state   <= S_HDR;
                        end else begin
                            gap_cnt <= gap_cnt + IDLE_W'(1);
                        end
                    end
                end
                S_FIN: begin
                    // final word is held a full tick, then the stream closes
                    if (tick) begin
                        out_valid <= 1'b0;
                        out_sop   <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (start_ok) begin
                full       <= 1'b0;
                pend       <= '0;
                sample_idx <= '0;
            end else if (load_adc) begin
                shadow <= adc_data;
                full   <= 1'b1;
                pend   <= en_l;
            end else if (load_st) begin
                shadow     <= st_pat;
                full       <= 1'b1;
                pend       <= en_l;
                sample_idx <= sample_idx + DATA_W'(1);
            end else if (emit) begin
                pend <= pend_nx;
                if (emptying) full <= 1'b0;
            end
        end
    end

endmodule

// File: doc/adc_pkt_streamer.md
Name: adc_pkt_streamer

Overview:
- Parametrised multi-channel successor to the single-stream ADC capture packet controller.
- Latches NUM_CH parallel ADC samples and serialises the enabled channels onto one pad-width data bus.
- Output is framed into headered packets, separated by programmable idle gaps and paced by a programmable divided read clock.
- Sits between the ADC capture front end and the PAD ADC_DATA/ADC_DATA_VALID/CLK_RD outputs. All configuration comes from the top regfile.

Parameters:
- DATA_W, 18, output/sample word width.
- NUM_CH, 4, number of ADC input channels.
- DIV_W, 8, width of clk_div.
- IDLE_W, 8, width of idle_length.
- CNT_W, 16, width of pkt_length and num_pkts.
- HDR_MARK, 18'h3A5A5, header word value (DATA_W bits).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- capture_start  in  1  single-cycle start pulse.
- self_test_mode  in  1  1 = internal counter pattern replaces ADC data.
- clk_div  in  DIV_W  read-clock divide ratio.
- idle_length  in  IDLE_W  gap length between packets, in ticks.
- pkt_length  in  CNT_W  sample sets per packet.
- num_pkts  in  CNT_W  packets per capture.
- ch_en  in  NUM_CH  channel enable mask.
- adc_data  in  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
- adc_valid  in  1  adc_data valid this cycle.
- out_data  out  DATA_W  serialised word.
- out_valid  out  1  out_data valid.
- out_sop  out  1  high with the header word.
- out_clk_rd  out  1  divided read clock.
- busy  out  1  capture in progress.
- done  out  1  one-cycle pulse at capture end.
- overflow  out  1  sticky: sample set dropped.

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE; all counters 0; shadow buffer empty.
  - Reset mid-capture aborts immediately with no done pulse.
- Config latch:
  - clk_div, idle_length, pkt_length, num_pkts, ch_en and self_test_mode are latched when capture_start is accepted.
  - Later changes to these inputs have no effect until the next capture.
- Divider:
  - D = (clk_div < 2) ? 2 : clk_div.
  - div_cnt runs 0..D-1 while busy; tick = (div_cnt == D-1).
  - out_clk_rd = (div_cnt >= D/2), using floor division; it is 0 when not busy.
  - out_* fields update only in the cycle after a tick, so they are stable across the out_clk_rd rising edge.
- FSM: IDLE -> HDR -> DATA -> GAP -> HDR ... -> IDLE.
  - IDLE:
    - capture_start, when latched pkt_length, num_pkts and ch_en are all non-zero: busy=1 next cycle, div_cnt=0, overflow cleared, enter HDR.
    - capture_start with any of them zero: done pulses 1 cycle later; busy stays 0.
  - HDR: after one tick, out_data = HDR_MARK, out_valid = 1, out_sop = 1; then enter DATA.
  - DATA:
    - Shadow load, ADC mode: adc_valid while the shadow is empty loads all NUM_CH words.
    - Shadow load, self-test mode: the shadow loads automatically when empty; channel k word = (sample_idx + k) mod 2^DATA_W. sample_idx resets to 0 at each capture start and increments per set.
    - Each tick emits the next enabled channel from the shadow, in ascending index, with out_valid = 1.
    - If the shadow is empty at a tick, out_valid = 0 and out_data holds its value.
    - After the last enabled channel is emitted, the shadow empties and the set count increments.
    - When the set count reaches pkt_length: enter GAP, or enter IDLE if the packet count reaches num_pkts.
  - GAP:
    - out_valid = 0 for idle_length ticks, then enter HDR.
    - idle_length = 0 goes directly to HDR on the next tick.
  - End of capture: busy falls and done pulses for 1 cycle on the same clock edge as the final word's out_valid deassertion.
- Overflow:
  - adc_valid while the shadow is full, in DATA state and ADC mode, drops that sample set and sets overflow.
  - overflow is cleared only by rst or an accepted capture_start.
  - adc_valid outside DATA state is ignored and does not set overflow.
- capture_start while busy is ignored.
- Simultaneous adc_valid and shadow-empty events in the same cycle: the load wins.
- Counters wrap nowhere: the maximum pkt_length and num_pkts (2^CNT_W - 1) must complete exactly.

Test Plan:
- Basic capture:
  - Stimulus: NUM_CH=4, ch_en=4'b1111, self_test_mode=1, clk_div=8, pkt_length=2, num_pkts=1, idle_length=15.
  - Required: out_clk_rd period is 8 clk. Words are HDR_MARK, 0, 1, 2, 3, 1, 2, 3, 4. Then done pulses once and busy returns to 0.
- Sparse mask with gap:
  - Stimulus: ch_en=4'b1010, self-test, pkt_length=3, num_pkts=2, idle_length=4.
  - Required: each packet is HDR followed by 1, 3, 2, 4, 3, 5. There are exactly 4 ticks with out_valid=0 between the packets, and out_sop is high only on headers.
- ADC mode with overflow:
  - Stimulus: adc_valid every clk, clk_div=8, ch_en=4'b1111.
  - Required: overflow rises during the first packet. Only whole sets appear in the output. The next capture_start clears overflow.
- Degenerate divider and zero config:
  - Stimulus 1: clk_div=0.
  - Required: behaves as D=2, so out_clk_rd toggles every clk.
  - Stimulus 2: ch_en=0, then capture_start.
  - Required: busy stays 0 and done pulses 1 cycle after start.
- Ignored start and config latching:
  - Stimulus: capture_start pulsed mid-packet; clk_div changed mid-capture.
  - Required: the stream is unchanged and the period stays at the latched value.
- Reset mid-capture:
  - Stimulus: rst=1 for 1 clk during DATA.
  - Required: next cycle all outputs are 0, no done pulse, FSM in IDLE. A following capture starts cleanly with sample_idx at 0.
